// File: rtl/not_chk_pkg.sv
// Shared types and helpers for the NOT-gate response checker.
package not_chk_pkg;

  // Checker FSM states; the numeric encoding is fixed so that external tools can decode it.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } chk_state_e;

  // Width of a counter that must hold the values 0..num_vec.
  function automatic int unsigned cnt_width(input int unsigned num_vec);
    return $clog2(num_vec + 1);
  endfunction

endpackage

// File: rtl/not_chk_stage.sv
// Stage-1 register: holds the accepted stimulus/response pair and its valid bit.
module not_chk_stage #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_z,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_z
);

  logic             r_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_z;

  // Capture a and z on accept; valid follows the accept strobe every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_z     <= '0;
    end else begin
      r_valid <= i_load;
      if (i_load) begin
        r_a <= i_a;
        r_z <= i_z;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_a     = r_a;
  assign o_z     = r_z;

endmodule

// File: rtl/not_resp_checker.sv
// Checks that a NOT DUT returns z == ~a over a run of NUM_VEC vectors.
// Accepted vectors pass through two register stages; counters settle two cycles after accept.
module not_resp_checker
  import not_chk_pkg::*;
#(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned NUM_VEC = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             in_valid,
  input  logic [WIDTH-1:0]                 a,
  input  logic [WIDTH-1:0]                 z,
  output logic                             in_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic [cnt_width(NUM_VEC)-1:0]    vec_cnt,
  output logic [cnt_width(NUM_VEC)-1:0]    err_cnt,
  output logic [cnt_width(NUM_VEC)-1:0]    fail_idx,
  output logic [WIDTH-1:0]                 fail_a,
  output logic [WIDTH-1:0]                 fail_z
);

  localparam int unsigned CW = cnt_width(NUM_VEC);

  chk_state_e       r_state;
  chk_state_e       w_state_next;

  logic             w_start;
  logic             w_accept;
  logic             w_last;

  logic             w_s1_valid;
  logic [WIDTH-1:0] w_s1_a;
  logic [WIDTH-1:0] w_s1_z;
  logic             w_mis;

  logic             r_s2_valid;
  logic             r_s2_mis;
  logic [WIDTH-1:0] r_s2_a;
  logic [WIDTH-1:0] r_s2_z;

  logic [CW-1:0]    r_acc_cnt;
  logic [CW-1:0]    r_vec_cnt;
  logic [CW-1:0]    r_err_cnt;
  logic [CW-1:0]    r_fail_idx;
  logic [WIDTH-1:0] r_fail_a;
  logic [WIDTH-1:0] r_fail_z;

  // start only counts when the checker is not mid-run.
  assign w_start  = start && ((r_state == StIdle) || (r_state == StDone));
  assign w_accept = in_valid && (r_state == StRun);
  assign w_last   = w_accept && (r_acc_cnt == CW'(NUM_VEC - 1));

  not_chk_stage #(
    .WIDTH (WIDTH)
  ) u_stage1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_start),
    .i_load  (w_accept),
    .i_a     (a),
    .i_z     (z),
    .o_valid (w_s1_valid),
    .o_a     (w_s1_a),
    .o_z     (w_s1_z)
  );

  // Case-inequality so an X/Z response counts as a mismatch in simulation.
  always_comb begin
    w_mis = (w_s1_z !== ~w_s1_a);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDrain;
      StDrain: if (!w_s1_valid && !r_s2_valid) w_state_next = StDone;
      StDone:  if (w_start) w_state_next = StRun;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    pass     = 1'b0;
    unique case (r_state)
      StIdle:  ;
      StRun: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StDrain: busy = 1'b1;
      StDone: begin
        done = 1'b1;
        pass = (r_err_cnt == '0);
      end
      default: ;
    endcase
  end

  // Count accepted vectors to find the last one of the run.
  always_ff @(posedge clk) begin
    if (!rst_n || w_start) begin
      r_acc_cnt <= '0;
    end else if (w_accept) begin
      r_acc_cnt <= r_acc_cnt + CW'(1);
    end
  end

  // Stage 2: register the compare result alongside the vector it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n || w_start) begin
      r_s2_valid <= 1'b0;
      r_s2_mis   <= 1'b0;
      r_s2_a     <= '0;
      r_s2_z     <= '0;
    end else begin
      r_s2_valid <= w_s1_valid;
      r_s2_mis   <= w_s1_valid && w_mis;
      r_s2_a     <= w_s1_a;
      r_s2_z     <= w_s1_z;
    end
  end

  // Result counters and first-failure capture; counts are bounded by NUM_VEC so never wrap.
  always_ff @(posedge clk) begin
    if (!rst_n || w_start) begin
      r_vec_cnt  <= '0;
      r_err_cnt  <= '0;
      r_fail_idx <= '0;
      r_fail_a   <= '0;
      r_fail_z   <= '0;
    end else if (r_s2_valid) begin
      r_vec_cnt <= r_vec_cnt + CW'(1);
      if (r_s2_mis) begin
        r_err_cnt <= r_err_cnt + CW'(1);
        if (r_err_cnt == '0) begin
          r_fail_idx <= r_vec_cnt;
          r_fail_a   <= r_s2_a;
          r_fail_z   <= r_s2_z;
        end
      end
    end
  end

  assign vec_cnt  = r_vec_cnt;
  assign err_cnt  = r_err_cnt;
  assign fail_idx = r_fail_idx;
  assign fail_a   = r_fail_a;
  assign fail_z   = r_fail_z;

endmodule

// File: tb/tb_not_resp_checker.sv
// Bench for not_resp_checker: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_not_resp_checker;

  localparam int unsigned W  = 5;
  localparam int unsigned NV = 10;
  localparam int unsigned CW = $clog2(NV + 1);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [W-1:0]  a;
  logic [W-1:0]  z;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] vec_cnt;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] fail_idx;
  logic [W-1:0]  fail_a;
  logic [W-1:0]  fail_z;

  not_resp_checker #(
    .WIDTH   (W),
    .NUM_VEC (NV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .a        (a),
    .z        (z),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .vec_cnt  (vec_cnt),
    .err_cnt  (err_cnt),
    .fail_idx (fail_idx),
    .fail_a   (fail_a),
    .fail_z   (fail_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a run is "accepting" until NV vectors are taken, each vector's
  // verdict lands two edges after it is taken, and done follows three edges after the last.
  typedef struct {
    logic [W-1:0] pa;
    logic [W-1:0] pz;
    longint       due;
  } pend_t;

  pend_t        pq[$];
  longint       cyc = 0;
  bit           m_armed = 0;
  bit           m_run, m_drain, m_done;
  int unsigned  m_acc, m_vec, m_err, m_fidx;
  logic [W-1:0] m_fa, m_fz;
  longint       m_done_at;

  task automatic model_clear();
    m_acc = 0; m_vec = 0; m_err = 0; m_fidx = 0;
    m_fa = '0; m_fz = '0;
    pq.delete();
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_clear();
      m_run = 0; m_drain = 0; m_done = 0;
      m_armed = 1;
    end else begin
      while (pq.size() > 0 && pq[0].due == cyc) begin
        pend_t p;
        p = pq.pop_front();
        if (p.pz !== ~p.pa) begin
          if (m_err == 0) begin
            m_fidx = m_vec; m_fa = p.pa; m_fz = p.pz;
          end
          m_err++;
        end
        m_vec++;
      end
      if (m_drain && cyc == m_done_at) begin
        m_drain = 0; m_done = 1;
      end
      if (start && ((!m_run && !m_drain && !m_done) || m_done)) begin
        model_clear();
        m_run = 1; m_done = 0;
      end else if (m_run && in_valid) begin
        pq.push_back('{pa: a, pz: z, due: cyc + 2});
        m_acc++;
        if (m_acc == NV) begin
          m_run = 0; m_drain = 1; m_done_at = cyc + 3;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_armed) begin
      chk("in_ready", 32'(in_ready), 32'(m_run));
      chk("busy",     32'(busy),     32'(m_run | m_drain));
      chk("done",     32'(done),     32'(m_done));
      chk("pass",     32'(pass),     32'(m_done && m_err == 0));
      chk("vec_cnt",  32'(vec_cnt),  m_vec);
      chk("err_cnt",  32'(err_cnt),  m_err);
      chk("fail_idx", 32'(fail_idx), m_fidx);
      chk("fail_a",   32'(fail_a),   32'(m_fa));
      chk("fail_z",   32'(fail_z),   32'(m_fz));
    end
  end

  longint last_acc;
  longint rise;

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Send n vectors with gap idle negedges between them; vector bad_idx gets (ba, bz).
  task automatic run_vecs(input int n, input int gap, input int bad_idx,
                          input logic [W-1:0] ba, input logic [W-1:0] bz);
    logic [W-1:0] va;
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap) @(negedge clk);
      va = W'($random);
      in_valid = 1'b1;
      a = (i == bad_idx) ? ba : va;
      z = (i == bad_idx) ? bz : ~va;
      @(negedge clk);
      in_valid = 1'b0;
      last_acc = cyc;
    end
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    rise = cyc;
    chk(nm, 32'(done), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; a = '0; z = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_done",  32'(done),    32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_vec",   32'(vec_cnt), 32'd0);

    // Clean run on consecutive cycles.
    pulse_start();
    run_vecs(10, 0, -1, '0, '0);
    wait_done("clean_done");
    chk("clean_pass",    32'(pass),    32'd1);
    chk("clean_vec",     32'(vec_cnt), 32'd10);
    chk("clean_err",     32'(err_cnt), 32'd0);
    chk("clean_latency", 32'(rise - last_acc), 32'd3);

    // Injected fault on vector 3.
    pulse_start();
    run_vecs(10, 0, 3, 5'h0A, 5'h14);
    wait_done("fault_done");
    chk("fault_err",  32'(err_cnt),  32'd1);
    chk("fault_idx",  32'(fail_idx), 32'd3);
    chk("fault_a",    32'(fail_a),   32'h0A);
    chk("fault_z",    32'(fail_z),   32'h14);
    chk("fault_pass", 32'(pass),     32'd0);

    // Restart from DONE after a failure clears the results; start in RUN is ignored.
    pulse_start();
    chk("restart_err",  32'(err_cnt),  32'd0);
    chk("restart_idx",  32'(fail_idx), 32'd0);
    chk("restart_fa",   32'(fail_a),   32'd0);
    chk("restart_fz",   32'(fail_z),   32'd0);
    run_vecs(4, 0, -1, '0, '0);
    pulse_start();
    chk("run_start_ready", 32'(in_ready), 32'd1);
    run_vecs(6, 0, -1, '0, '0);
    wait_done("second_done");
    chk("second_vec",  32'(vec_cnt), 32'd10);
    chk("second_pass", 32'(pass),    32'd1);

    // Gapped run, then an extra vector after the run is full.
    pulse_start();
    run_vecs(10, 2, -1, '0, '0);
    chk("gap_ready_after", 32'(in_ready), 32'd0);
    in_valid = 1'b1; a = 5'h01; z = 5'h00;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done("gap_done");
    chk("gap_vec",  32'(vec_cnt), 32'd10);
    chk("gap_err",  32'(err_cnt), 32'd0);
    chk("gap_pass", 32'(pass),    32'd1);

    // Reset in the middle of a run aborts it.
    pulse_start();
    run_vecs(4, 0, -1, '0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy",  32'(busy),    32'd0);
    chk("abort_done",  32'(done),    32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_vec",  32'(vec_cnt), 32'd0);
    chk("abort_done2", 32'(done),   32'd0);
    pulse_start();
    run_vecs(10, 0, -1, '0, '0);
    wait_done("rerun_done");
    chk("rerun_vec",  32'(vec_cnt), 32'd10);
    chk("rerun_pass", 32'(pass),    32'd1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/not_resp_checker.md
NOT_RESP_CHECKER -- requirements
Module: not_resp_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 5: bit width of stimulus a and DUT response z.
REQ-002 SHALL have parameter NUM_VEC, default 10: number of vectors per check run; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1: begins a run when sampled high in IDLE or DONE.
REQ-006 SHALL have port in_valid, input, 1: a and z carry a vector this cycle.
REQ-007 SHALL have port a, input, WIDTH: stimulus applied to the NOT DUT.
REQ-008 SHALL have port z, input, WIDTH: response observed from the NOT DUT.
REQ-009 SHALL have port in_ready, output, 1: checker accepts a vector this cycle.
REQ-010 SHALL have port busy, output, 1: high in RUN and DRAIN.
REQ-011 SHALL have port done, output, 1: high in DONE.
REQ-012 SHALL have port pass, output, 1: high in DONE when err_cnt equals 0.
REQ-013 SHALL have port vec_cnt, output, CW: vectors compared so far; CW = $clog2(NUM_VEC+1).
REQ-014 SHALL have port err_cnt, output, CW: mismatching vectors so far.
REQ-015 SHALL have port fail_idx, output, CW: zero-based index of the first mismatching vector.
REQ-016 SHALL have ports fail_a and fail_z, output, WIDTH each: a and z of the first mismatching vector.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-018 SHALL move IDLE->RUN and DONE->RUN on start=1, clearing vec_cnt, err_cnt, fail_idx, fail_a, fail_z, the accept counter and the pipeline on that edge.
REQ-019 SHALL ignore start in RUN and DRAIN.
REQ-020 SHALL drive in_ready=1 only in RUN; a vector is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-021 SHALL discard in_valid in IDLE, DRAIN and DONE, with no counter change.
REQ-022 SHALL move RUN->DRAIN on the edge that accepts vector NUM_VEC.
REQ-023 SHALL move DRAIN->DONE when the pipeline holds no valid vector.
REQ-024 SHALL hold DONE and all result outputs until start or reset.
REQ-025 SHALL pipeline in two stages: stage 1 registers a, z and the valid bit; stage 2 compares z against the bitwise inverse of a and updates the counters.
REQ-026 SHALL update vec_cnt and err_cnt exactly 2 cycles after the accept edge.
REQ-027 SHALL increment vec_cnt by 1 per compared vector.
REQ-028 SHALL increment err_cnt by 1 when any bit of z differs from the inverse of a.
REQ-029 SHALL capture fail_idx (equal to vec_cnt before the increment), fail_a and fail_z only on the first mismatch of a run.
REQ-030 SHALL never wrap vec_cnt or err_cnt, since both are bounded by NUM_VEC.
REQ-031 SHALL accept gaps in in_valid of any length in RUN without timeout.
REQ-032 SHALL treat X or Z on z as a mismatch in simulation only; synthesis behaviour is a plain compare.

Reset
REQ-033 SHALL, on rst_n=0 at a clock edge, enter IDLE and clear every output, counter, capture register and pipeline valid bit to 0.
REQ-034 SHALL treat a reset mid-run as an abort: no partial result is kept, and done stays 0 until a new run completes.

Structure
REQ-035 SHALL place the FSM state encoding (2-bit: IDLE=0, RUN=1, DRAIN=2, DONE=3) in a shared package, not_chk_pkg.
REQ-036 SHALL place the CW width function in not_chk_pkg.
REQ-037 SHALL have one natural sub-module, not_chk_stage, holding the stage-1 register of a, z and valid.
REQ-038 SHALL keep the compare and counters in the top module; target size is 120-250 RTL lines.

Verification
REQ-039 SHALL test a clean run: WIDTH=5, NUM_VEC=10, start, 10 vectors from $random with z=~a on consecutive cycles -> done=1, pass=1, vec_cnt=10, err_cnt=0, done rising 3 cycles after the last accept.
REQ-040 SHALL test an injected fault: vector 3 has a=5'h0A, z=5'h15 with bit 0 flipped to give 5'h14 -> err_cnt=1, fail_idx=3, fail_a=5'h0A, fail_z=5'h14, pass=0.
REQ-041 SHALL test a gapped run: in_valid pulsed on every 3rd negedge of clk for 10 vectors -> vec_cnt=10, in_ready=0 after the 10th accept, and an 11th in_valid ignored.
REQ-042 SHALL test a mid-run reset: rst_n=0 for 1 cycle after 4 accepts -> IDLE, all outputs 0; a new start runs cleanly to vec_cnt=10.
REQ-043 SHALL test start handling: start pulsed in RUN -> no effect; start in DONE after a failing run -> err_cnt=0 and fail_* cleared, and a clean second run gives pass=1.
